// File: rtl/cve2_obi_wb_bridge.sv
// Data-side OBI to Wishbone classic bridge: one outstanding access, each issued as a single
// Wishbone cycle, with an optional bus timeout that terminates a dead cycle with an error.
module cve2_obi_wb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e            r_state, w_state_next;
  logic              r_we, w_we;
  logic [3:0]        r_sel, w_sel;
  logic [31:0]       r_adr, w_adr;
  logic [31:0]       r_dat, w_dat;
  logic [31:0]       r_rdata, w_rdata;
  logic              r_err, w_err;
  logic [CntW-1:0]   r_cnt, w_cnt;
  logic              w_timeout_hit;

  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CntLast);

  always_comb begin
    w_state_next = r_state;
    w_we         = r_we;
    w_sel        = r_sel;
    w_adr        = r_adr;
    w_dat        = r_dat;
    w_rdata      = r_rdata;
    w_err        = r_err;
    w_cnt        = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (req_i) begin
          w_we         = we_i;
          w_sel        = be_i;
          w_adr        = {addr_i[31:2], 2'b00};
          w_dat        = wdata_i;
          w_cnt        = '0;
          w_state_next = StBus;
        end
      end
      StBus: begin
        if (r_cnt != CntMax) w_cnt = r_cnt + 1'b1;
        // Slave error wins over ack; the timeout only fires when the slave is silent.
        if (wb_err_i) begin
          w_err        = 1'b1;
          w_rdata      = '0;
          w_state_next = StResp;
        end else if (wb_ack_i) begin
          w_err        = 1'b0;
          w_rdata      = r_we ? 32'h0 : wb_dat_i;
          w_state_next = StResp;
        end else if (w_timeout_hit) begin
          w_err        = 1'b1;
          w_rdata      = '0;
          w_state_next = StResp;
        end
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_we    <= w_we;
      r_sel   <= w_sel;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
      r_rdata <= w_rdata;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
    end
  end

  assign gnt_o    = (r_state == StIdle) && req_i && !rst_i;
  assign wb_cyc_o = (r_state == StBus);
  assign wb_stb_o = wb_cyc_o;
  assign wb_we_o  = r_we;
  assign wb_sel_o = r_sel;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign rvalid_o = (r_state == StResp);
  assign err_o    = rvalid_o && r_err;
  assign rdata_o  = r_rdata;
  assign busy_o   = (r_state != StIdle);

endmodule
